// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the queued-result entry type for the writeback stage.
package wb_pkg;
    localparam int WB_DW    = 8;
    localparam int WB_AW    = 3;
    localparam int WB_DEPTH = 4;
    localparam int WB_PW    = $clog2(WB_DEPTH);
    localparam int WB_CW    = WB_PW + 1;
    typedef struct packed {logic [WB_AW-1:0] dst; logic [WB_DW-1:0] data;} wb_entry_t;
endpackage

// File: rtl/wb_if.sv
// wb_if: producer handshakes, register-file write beat and forwarding lookups of the writeback stage.
interface wb_if;
    import wb_pkg::*;
    logic              ld_valid, ld_ready, alu_valid, alu_ready;
    logic [WB_AW-1:0]  ld_dst, alu_dst, wr_addr, rd_addrA, rd_addrB;
    logic [WB_DW-1:0]  ld_data, alu_data, dat_out, fwdA_data, fwdB_data;
    logic              wr_en, busy, fwdA_hit, fwdB_hit;
    modport slave (
        input  ld_valid, ld_dst, ld_data, alu_valid, alu_dst, alu_data, rd_addrA, rd_addrB,
        output ld_ready, alu_ready, wr_en, wr_addr, dat_out, busy,
               fwdA_hit, fwdA_data, fwdB_hit, fwdB_data
    );
    modport master (
        output ld_valid, ld_dst, ld_data, alu_valid, alu_dst, alu_data, rd_addrA, rd_addrB,
        input  ld_ready, alu_ready, wr_en, wr_addr, dat_out, busy,
               fwdA_hit, fwdA_data, fwdB_hit, fwdB_data
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: dual-push single-pop circular queue; push0 lands ahead of push1 in the same cycle.
module wb_fifo
    import wb_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push0,
    input  wb_entry_t                     din0,
    input  logic                          push1,
    input  wb_entry_t                     din1,
    input  logic                          pop,
    output logic [WB_CW-1:0]              count,
    output wb_entry_t                     head,
    output logic [WB_DEPTH-1:0]           vld,
    output wb_entry_t [WB_DEPTH-1:0]      ent
);
    logic [WB_PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [WB_CW-1:0] count_q, count_d;
    wb_entry_t        mem_q [WB_DEPTH];
    wb_entry_t        mem_d [WB_DEPTH];

    // ent/vld are presented oldest-first so the forwarding search can favour higher indices
    always_comb begin
        mem_d = mem_q;
        if (push0) mem_d[wr_ptr_q] = din0;
        if (push1) mem_d[push0 ? wr_ptr_q + WB_PW'(1) : wr_ptr_q] = din1;
        wr_ptr_d = wr_ptr_q + WB_PW'(push0) + WB_PW'(push1);
        rd_ptr_d = rd_ptr_q + WB_PW'(pop);
        count_d  = count_q + WB_CW'(push0) + WB_CW'(push1) - WB_CW'(pop);
        for (int i = 0; i < WB_DEPTH; i++) begin
            ent[i] = mem_q[rd_ptr_q + WB_PW'(i)];
            vld[i] = WB_CW'(i) < count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/wb_stage.sv
// wb_stage: orders ALU/load results into the register-file write port.
// Define WB_FWD_EN to build forwarding from queued results and the current write beat.
module wb_stage
    import wb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    wb_if.slave  bus
);
    localparam logic [WB_CW-1:0] DEPTH_C = WB_CW'(WB_DEPTH);

    logic [WB_CW-1:0]          count, free;
    wb_entry_t                 head;
    logic [WB_DEPTH-1:0]       vld;
    wb_entry_t [WB_DEPTH-1:0]  ent;
    logic                      ld_push, alu_push, pop;
    logic                      wr_en_q, wr_en_d;
    logic [WB_AW-1:0]          wr_addr_q, wr_addr_d;
    logic [WB_DW-1:0]          dat_out_q, dat_out_d;

    // readies look only at occupancy and ld_valid, so never at their own handshakes
    assign free          = DEPTH_C - count;
    assign bus.ld_ready  = free != '0;
    assign bus.alu_ready = free >= WB_CW'(2) || (free != '0 && !bus.ld_valid);
    assign ld_push       = bus.ld_valid && bus.ld_ready;
    assign alu_push      = bus.alu_valid && bus.alu_ready;
    assign pop           = count != '0;

    wb_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push0 (ld_push),
        .din0  ({bus.ld_dst, bus.ld_data}),
        .push1 (alu_push),
        .din1  ({bus.alu_dst, bus.alu_data}),
        .pop   (pop),
        .count (count),
        .head  (head),
        .vld   (vld),
        .ent   (ent)
    );

    always_comb begin
        wr_en_d   = pop;
        wr_addr_d = pop ? head.dst : wr_addr_q;
        dat_out_d = pop ? head.data : dat_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            dat_out_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            dat_out_q <= dat_out_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.dat_out = dat_out_q;
    assign bus.busy    = pop || wr_en_q;

`ifdef WB_FWD_EN
    logic [WB_AW-1:0] ra  [2];
    logic             hit [2];
    logic [WB_DW-1:0] fd  [2];

    // write beat is the oldest candidate; later queue matches override it
    always_comb begin
        ra[0] = bus.rd_addrA;
        ra[1] = bus.rd_addrB;
        for (int p = 0; p < 2; p++) begin
            hit[p] = wr_en_q && wr_addr_q == ra[p];
            fd[p]  = hit[p] ? dat_out_q : '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                if (vld[i] && ent[i].dst == ra[p]) begin
                    hit[p] = 1'b1;
                    fd[p]  = ent[i].data;
                end
            end
        end
    end

    assign bus.fwdA_hit  = hit[0];
    assign bus.fwdA_data = fd[0];
    assign bus.fwdB_hit  = hit[1];
    assign bus.fwdB_data = fd[1];
`else
    logic unused_fwd;
    assign unused_fwd    = ^{vld, ent, bus.rd_addrA, bus.rd_addrB};
    assign bus.fwdA_hit  = 1'b0;
    assign bus.fwdA_data = '0;
    assign bus.fwdB_hit  = 1'b0;
    assign bus.fwdB_data = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus with an occupancy model feeding an in-order scoreboard.
module tb_wb_stage;
    import wb_pkg::*;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    wb_if bus();

    wb_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int        errors = 0, checks = 0;
    int        mc     = 0;
    logic      exp_wr = 1'b0;
    logic      la, aa;
    logic [2:0] last_a = '0;
    logic [7:0] last_d = '0;
    wb_entry_t sb [$];
    wb_entry_t e;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: acceptance from expected occupancy, expected writes pushed in program order
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc     = 0;
            exp_wr = 1'b0;
            last_a = '0;
            last_d = '0;
            sb.delete();
        end else begin
            la     = bus.ld_valid && mc < 4;
            aa     = bus.alu_valid && (mc <= 2 || (mc == 3 && !bus.ld_valid));
            exp_wr = mc > 0;
            if (la) sb.push_back('{dst: bus.ld_dst, data: bus.ld_data});
            if (aa) sb.push_back('{dst: bus.alu_dst, data: bus.alu_data});
            mc = mc + int'(la) + int'(aa) - int'(mc > 0);
        end
    end

    always @(negedge clk) begin
        chk("ld_ready", bus.ld_ready, mc < 4);
        chk("alu_ready", bus.alu_ready, mc <= 2 || (mc == 3 && !bus.ld_valid));
        chk("busy", bus.busy, mc > 0 || exp_wr);
        chk("wr_en", bus.wr_en, exp_wr);
        if (exp_wr && sb.size() > 0) begin
            e      = sb.pop_front();
            last_a = e.dst;
            last_d = e.data;
        end
        chk("wr_addr", bus.wr_addr, last_a);
        chk("dat_out", bus.dat_out, last_d);
    end

    task automatic drive(logic lv, logic [2:0] ld, logic [7:0] ldat, logic av, logic [2:0] ad, logic [7:0] adat);
        @(posedge clk);
        #1;
        bus.ld_valid  = lv;
        bus.ld_dst    = ld;
        bus.ld_data   = ldat;
        bus.alu_valid = av;
        bus.alu_dst   = ad;
        bus.alu_data  = adat;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.rd_addrA = 3'd0;
        bus.rd_addrB = 3'd0;
        bus.ld_valid = 1'b1; bus.ld_dst = 3'd6; bus.ld_data = 8'hEE;
        bus.alu_valid = 1'b1; bus.alu_dst = 3'd7; bus.alu_data = 8'hFF;
        // producers valid while held in reset: nothing may be written
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_busy", bus.busy, 0);
        drive(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
        rst_n = 1'b1;
        idle(4);
        drive(0, 0, 0, 1, 3'd3, 8'hA5);
        idle(3);
        drive(1, 3'd2, 8'h11, 1, 3'd2, 8'h22);
        idle(3);
        for (int i = 0; i < 6; i++) drive(1, 3'(i), 8'(8'h40 + i), 1, 3'(7 - i), 8'(8'h80 + i));
        idle(8);
        // mid-operation reset with three entries queued and one beat in flight
        drive(1, 3'd4, 8'h44, 1, 3'd5, 8'h55);
        drive(1, 3'd6, 8'h66, 1, 3'd7, 8'h77);
        @(posedge clk);
        #1;
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_wr_en", bus.wr_en, 0);
        chk("async_wr_addr", bus.wr_addr, 0);
        chk("async_dat_out", bus.dat_out, 0);
        chk("async_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        // forwarding: two queued writes to r5, youngest must win
        drive(1, 3'd5, 8'h10, 1, 3'd5, 8'h20);
        @(posedge clk);
        #1;
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        bus.rd_addrA  = 3'd5;
        bus.rd_addrB  = 3'd6;
        #1;
        chk("fwdA_hit_q", bus.fwdA_hit, FWD);
        chk("fwdA_data_q", bus.fwdA_data, FWD ? 8'h20 : 8'h00);
        chk("fwdB_hit_q", bus.fwdB_hit, 0);
        @(posedge clk);
        #1;
        chk("fwdA_hit_mix", bus.fwdA_hit, FWD);
        chk("fwdA_data_mix", bus.fwdA_data, FWD ? 8'h20 : 8'h00);
        @(posedge clk);
        #1;
        chk("fwdA_hit_beat", bus.fwdA_hit, FWD);
        chk("fwdA_data_beat", bus.fwdA_data, FWD ? 8'h20 : 8'h00);
        bus.rd_addrB = 3'd5;
        #1;
        chk("fwdB_hit_beat", bus.fwdB_hit, FWD);
        @(posedge clk);
        #1;
        chk("fwdA_hit_none", bus.fwdA_hit, 0);
        idle(10);
        chk("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
